// File: rtl/riscv_mem_loader.sv
// riscv_mem_loader: boot-time sequencer. It packs host words in pairs into
// instruction and data memory entries and drives the core's external-load
// port. The core is held in reset until the load completes.
//
// Ports:
//   clk, reset (async, active-low)
//   start, inst_len, data_len         load request; lengths sampled on start
//   s_valid, s_data, s_ready          host word stream (valid/ready)
//   enable_load_ex_mem                external-load enable to core memories
//   InstExMemAddress/Data1/Data2      instruction entry being written
//   DataExMemAddress/Data1/Data2      data entry being written
//   core_hold, busy, done, err        core reset hold and status
module riscv_mem_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   inst_len,
  input  logic [ADDR_W:0]   data_len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [31:0]       InstExMemData1,
  output logic [31:0]       InstExMemData2,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [31:0]       DataExMemData1,
  output logic [31:0]       DataExMemData2,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INST  = 3'd1,
    S_DATA  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [LEN_W-1:0]    r_inst_len;
  logic [LEN_W-1:0]    r_data_len;
  logic [LEN_W-1:0]    r_inst_cnt;
  logic [LEN_W-1:0]    r_data_cnt;
  logic                r_half;
  logic [WORD_W-1:0]   r_shadow;

  logic                r_s_ready;
  logic                r_enable;
  logic                r_core_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_inst_addr;
  logic [WORD_W-1:0]   r_inst_d1;
  logic [WORD_W-1:0]   r_inst_d2;
  logic [ADDR_W-1:0]   r_data_addr;
  logic [WORD_W-1:0]   r_data_d1;
  logic [WORD_W-1:0]   r_data_d2;

  logic                w_start_seen;
  logic                w_len_bad;
  logic                w_start_go;
  logic                w_start_bad;
  logic                w_hs;
  logic                w_commit;
  logic                w_inst_last;
  logic                w_data_last;

  // start is only honoured while no load is in flight
  assign w_start_seen = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_len_bad    = (inst_len > LEN_W'(DEPTH)) || (data_len > LEN_W'(DEPTH));
  assign w_start_go   = w_start_seen && !w_len_bad;
  assign w_start_bad  = w_start_seen && w_len_bad;

  // s_ready is registered and only high in INST/DATA, so it qualifies the phase
  assign w_hs        = s_valid && r_s_ready;
  assign w_commit    = w_hs && r_half;
  assign w_inst_last = (r_inst_cnt + LEN_W'(1)) == r_inst_len;
  assign w_data_last = (r_data_cnt + LEN_W'(1)) == r_data_len;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; empty phases are skipped straight from start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_go) begin
          if (inst_len != '0)      w_next = S_INST;
          else if (data_len != '0) w_next = S_DATA;
          else                     w_next = S_FLUSH;
        end
      end
      S_INST: begin
        if (w_commit && w_inst_last) begin
          w_next = (r_data_len == '0) ? S_FLUSH : S_DATA;
        end
      end
      S_DATA: begin
        if (w_commit && w_data_last) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with r_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_ready   <= 1'b0;
      r_enable    <= 1'b0;
      r_core_hold <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_s_ready   <= (w_next == S_INST) || (w_next == S_DATA);
      r_enable    <= (w_next == S_INST) || (w_next == S_DATA) || (w_next == S_FLUSH);
      r_core_hold <= (w_next != S_DONE);
      r_busy      <= (w_next == S_INST) || (w_next == S_DATA) || (w_next == S_FLUSH);
      r_done      <= (w_next == S_DONE);
    end
  end

  // Word packing, entry counters and load-port entry registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst_len  <= '0;
      r_data_len  <= '0;
      r_inst_cnt  <= '0;
      r_data_cnt  <= '0;
      r_half      <= 1'b0;
      r_shadow    <= '0;
      r_err       <= 1'b0;
      r_inst_addr <= '0;
      r_inst_d1   <= '0;
      r_inst_d2   <= '0;
      r_data_addr <= '0;
      r_data_d1   <= '0;
      r_data_d2   <= '0;
    end else if (w_start_go) begin
      // Clearing the entry outputs makes idle phases write zero to entry 0
      r_inst_len  <= inst_len;
      r_data_len  <= data_len;
      r_inst_cnt  <= '0;
      r_data_cnt  <= '0;
      r_half      <= 1'b0;
      r_err       <= 1'b0;
      r_inst_addr <= '0;
      r_inst_d1   <= '0;
      r_inst_d2   <= '0;
      r_data_addr <= '0;
      r_data_d1   <= '0;
      r_data_d2   <= '0;
    end else if (w_start_bad) begin
      r_err <= 1'b1;
    end else if (w_hs) begin
      if (!r_half) begin
        r_shadow <= s_data;
        r_half   <= 1'b1;
      end else begin
        r_half <= 1'b0;
        if (r_state == S_INST) begin
          r_inst_addr <= r_inst_cnt[ADDR_W-1:0];
          r_inst_d1   <= r_shadow;
          r_inst_d2   <= s_data;
          r_inst_cnt  <= r_inst_cnt + LEN_W'(1);
        end else begin
          r_data_addr <= r_data_cnt[ADDR_W-1:0];
          r_data_d1   <= r_shadow;
          r_data_d2   <= s_data;
          r_data_cnt  <= r_data_cnt + LEN_W'(1);
        end
      end
    end
  end

  assign s_ready            = r_s_ready;
  assign enable_load_ex_mem = r_enable;
  assign core_hold          = r_core_hold;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign InstExMemAddress   = r_inst_addr;
  assign InstExMemData1     = r_inst_d1;
  assign InstExMemData2     = r_inst_d2;
  assign DataExMemAddress   = r_data_addr;
  assign DataExMemData1     = r_data_d1;
  assign DataExMemData2     = r_data_d2;

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Testbench for riscv_mem_loader: directed loads, expected entries and load
// latency queued by the stimulus, checked by a monitor when done rises.
module tb_riscv_mem_loader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   inst_len;
  logic [ADDR_W:0]   data_len;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              enable_load_ex_mem;
  logic [ADDR_W-1:0] InstExMemAddress;
  logic [31:0]       InstExMemData1;
  logic [31:0]       InstExMemData2;
  logic [ADDR_W-1:0] DataExMemAddress;
  logic [31:0]       DataExMemData1;
  logic [31:0]       DataExMemData2;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  riscv_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .inst_len           (inst_len),
    .data_len           (data_len),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .enable_load_ex_mem (enable_load_ex_mem),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .DataExMemAddress   (DataExMemAddress),
    .DataExMemData1     (DataExMemData1),
    .DataExMemData2     (DataExMemData2),
    .core_hold          (core_hold),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_inst;
    int          addr;
    logic [31:0] d1;
    logic [31:0] d2;
  } entry_t;

  entry_t exp_q[$];
  int     lat_q[$];
  int     n_checks = 0;
  int     n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model written every enabled cycle, like the core memories
  logic [31:0] im1 [DEPTH];
  logic [31:0] im2 [DEPTH];
  logic [31:0] dm1 [DEPTH];
  logic [31:0] dm2 [DEPTH];
  int          cyc;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (start && !busy) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        im1[i] = 32'hDEADBEEF; im2[i] = 32'hDEADBEEF;
        dm1[i] = 32'hDEADBEEF; dm2[i] = 32'hDEADBEEF;
      end
      cyc = 0;
    end else begin
      cyc++;
    end
    if (enable_load_ex_mem) begin
      im1[InstExMemAddress] = InstExMemData1;
      im2[InstExMemAddress] = InstExMemData2;
      dm1[DataExMemAddress] = DataExMemData1;
      dm2[DataExMemAddress] = DataExMemData2;
    end
    if (done && !prev_done) begin
      if (lat_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("done_latency", 32'(cyc), 32'(lat_q.pop_front()));
        while (exp_q.size() > 0) begin
          entry_t e;
          e = exp_q.pop_front();
          if (e.is_inst) begin
            chk($sformatf("inst[%0d].d1", e.addr), im1[e.addr], e.d1);
            chk($sformatf("inst[%0d].d2", e.addr), im2[e.addr], e.d2);
          end else begin
            chk($sformatf("data[%0d].d1", e.addr), dm1[e.addr], e.d1);
            chk($sformatf("data[%0d].d2", e.addr), dm2[e.addr], e.d2);
          end
        end
      end
    end
    prev_done = done;
  end

  logic [31:0] w [8];

  // One load: queue expectations, pulse start, stream words, wait for done
  task automatic do_load(input int ilen, input int dlen, input bit gap, input int poke);
    int     n;
    int     t;
    bit     rdy_seen;
    entry_t e;
    n = 2 * (ilen + dlen);
    for (int i = 0; i < ilen; i++) begin
      e.is_inst = 1'b1; e.addr = i; e.d1 = w[2*i]; e.d2 = w[2*i+1];
      exp_q.push_back(e);
    end
    for (int j = 0; j < dlen; j++) begin
      e.is_inst = 1'b0; e.addr = j; e.d1 = w[2*(ilen+j)]; e.d2 = w[2*(ilen+j)+1];
      exp_q.push_back(e);
    end
    if (ilen == 0) begin
      e.is_inst = 1'b1; e.addr = 0; e.d1 = '0; e.d2 = '0; exp_q.push_back(e);
    end
    if (dlen == 0) begin
      e.is_inst = 1'b0; e.addr = 0; e.d1 = '0; e.d2 = '0; exp_q.push_back(e);
    end
    lat_q.push_back(gap ? 2*n + 1 : n + 2);

    @(posedge clk); #1;
    inst_len = (ADDR_W+1)'(ilen);
    data_len = (ADDR_W+1)'(dlen);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_after_start", {31'd0, core_hold}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, s_ready}, (n != 0) ? 32'd1 : 32'd0);

    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = w[k];
      if (k == poke) begin
        start = 1'b1; inst_len = '0; data_len = '0;
      end
      t = 0;
      while (!s_ready && t < 50) begin
        @(posedge clk); #1; t++;
      end
      if (t == 50) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      start   = 1'b0;
      s_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end

    t = 0;
    rdy_seen = 1'b0;
    while (!done && t < 60) begin
      if (s_ready) rdy_seen = 1'b1;
      @(negedge clk); t++;
    end
    if (t == 60) begin
      chk("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
      lat_q.delete();
    end
    if (n == 0) chk("ready_never", {31'd0, rdy_seen}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("done_high", {31'd0, done}, 32'd1);
    chk("hold_released", {31'd0, core_hold}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".core_hold"}, {31'd0, core_hold}, 32'd1);
    chk({tag, ".enable"}, {31'd0, enable_load_ex_mem}, 32'd0);
    chk({tag, ".s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".inst_addr"}, 32'(InstExMemAddress), 32'd0);
    chk({tag, ".inst_d1"}, InstExMemData1, 32'd0);
    chk({tag, ".inst_d2"}, InstExMemData2, 32'd0);
    chk({tag, ".data_d1"}, DataExMemData1, 32'd0);
  endtask

  task automatic set_basic_words();
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    w[4] = 32'hA0; w[5] = 32'hA1; w[6] = 32'h0;  w[7] = 32'h0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; inst_len = '0; data_len = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Basic back-to-back load
    set_basic_words();
    do_load(2, 1, 1'b0, -1);

    // Same load with valid gaps, started from DONE
    do_load(2, 1, 1'b1, -1);

    // Instruction phase skipped
    w[0] = 32'hB0; w[1] = 32'hB1;
    do_load(0, 1, 1'b0, -1);

    // Both lengths zero
    do_load(0, 0, 1'b0, -1);

    // start mid-DATA ignored
    w[0] = 32'hC0; w[1] = 32'hC1; w[2] = 32'hC2; w[3] = 32'hC3;
    w[4] = 32'hC4; w[5] = 32'hC5;
    do_load(1, 2, 1'b0, 3);

    // Reset mid-load after three words
    set_basic_words();
    @(posedge clk); #1;
    inst_len = 10'd2; data_len = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = w[k];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("pre_reset_inst_d1", InstExMemData1, 32'h11);
    #2 reset = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1 reset = 1'b1;
    do_load(2, 1, 1'b0, -1);

    // Length error from IDLE
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    inst_len = 10'd513; data_len = 10'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len_err", {31'd0, err}, 32'd1);
    chk("len_err_hold", {31'd0, core_hold}, 32'd1);
    chk("len_err_busy", {31'd0, busy}, 32'd0);
    chk("len_err_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    chk("len_err_sticky", {31'd0, err}, 32'd1);
    w[0] = 32'hE0; w[1] = 32'hE1;
    do_load(1, 0, 1'b0, -1);
    chk("err_cleared", {31'd0, err}, 32'd0);

    chk("queue_drained", 32'(exp_q.size() + lat_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
